multicycle_ctrl: RTL

- Multi-cycle control FSM for the processor datapath; it sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Decodes the latched instruction word and drives every datapath select, including the 2-bit imm_ctrl select of the immediate extender.
- Owns the instruction- and data-memory request/ready handshakes, with a timeout watchdog on both.

---
 rtl/multicycle_ctrl_pkg.sv | 82 ++++++++
 rtl/multicycle_ctrl_if.sv | 25 ++
 rtl/multicycle_ctrl_mem_watchdog.sv | 38 +++
 rtl/multicycle_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg
// Shared types and constants for the multi-cycle controller: FSM state
// encoding, instruction classes, opcodes, immediate-extender selects and
// the instruction-header decode helper.
// ---------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CLS_ALU_R = 2'b00,
        CLS_ALU_I = 2'b01,
        CLS_MEM   = 2'b10,
        CLS_CTRL  = 2'b11
    } cls_t;

    // memory class
    localparam logic [3:0] OP_LDR  = 4'b0000;
    localparam logic [3:0] OP_STR  = 4'b0001;
    // control class
    localparam logic [3:0] OP_B    = 4'b0000;
    localparam logic [3:0] OP_BEQ  = 4'b0001;
    localparam logic [3:0] OP_BNE  = 4'b0010;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [1:0] IMM_Z19 = 2'b00;
    localparam logic [1:0] IMM_S19 = 2'b01;
    localparam logic [1:0] IMM_S23 = 2'b10;

    // ALU operations the controller picks itself: address add for memory
    // accesses, compare-by-subtract for conditional branches.
    localparam logic [3:0] ALU_ADD = 4'b1000;
    localparam logic [3:0] ALU_SUB = 4'b1001;

    typedef struct packed {
        cls_t       cls;
        logic [3:0] op;
        logic       illegal;
        logic [1:0] imm_ctrl;
        logic [3:0] alu_op;
        logic       alu_src;
    } dec_t;

    // hdr = instr[31:26]
    function automatic dec_t decode(input logic [5:0] hdr);
        dec_t d;
        d          = '0;
        d.cls      = cls_t'(hdr[5:4]);
        d.op       = hdr[3:0];
        d.alu_op   = hdr[3:0];
        d.imm_ctrl = IMM_Z19;
        case (d.cls)
            CLS_ALU_I: begin
                d.alu_src  = 1'b1;
                d.imm_ctrl = hdr[3] ? IMM_S19 : IMM_Z19;
            end
            CLS_MEM: begin
                d.alu_src  = 1'b1;
                d.imm_ctrl = IMM_S19;
                d.alu_op   = ALU_ADD;
                d.illegal  = (d.op != OP_LDR) && (d.op != OP_STR);
            end
            CLS_CTRL: begin
                d.imm_ctrl = IMM_S23;
                d.alu_op   = ALU_SUB;
                d.illegal  = (d.op != OP_B) && (d.op != OP_BEQ) &&
                             (d.op != OP_BNE) && (d.op != OP_HALT);
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_if
// Instruction- and data-memory handshake bundle.
//   imem_req / imem_ready / instr   : instruction fetch
//   dmem_req / dmem_ready / dmem_we : data access (dmem_we=1 is a store)
// master = controller side, slave = memory side.
// ---------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ready;
    logic [31:0] instr;
    logic        dmem_req;
    logic        dmem_ready;
    logic        dmem_we;

    modport master (
        output imem_req, dmem_req, dmem_we,
        input  imem_ready, instr, dmem_ready
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we,
        output imem_ready, instr, dmem_ready
    );
endinterface

// File: rtl/multicycle_ctrl_mem_watchdog.sv
// ---------------------------------------------------------------------------
// mem_watchdog
// Wait counter shared by the instruction and data handshakes (only one
// request is ever outstanding).
//   start  : clears the count; asserted on the edge that raises a request
//   active : a request is outstanding
//   ready  : ready of the outstanding request
//   expire : request has waited TIMEOUT cycles without ready
// ---------------------------------------------------------------------------
module mem_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic active,
    input  logic ready,
    output logic expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (active && !ready && (cnt != LAST)) begin
            cnt <= cnt + 8'd1;
        end
    end

    // ready in the final waiting cycle takes priority over the timeout
    assign expire = active && !ready && (cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Sequences fetch/decode/execute/memory/writeback for one instruction at a
// time and drives all datapath selects.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   run           : start fetching (looked at only while idle in FETCH)
//   mem           : memory handshake bundle (master side)
//   zero          : ALU zero flag, used in EXEC for conditional branches
//   ir_we, pc_we, pc_src, reg_we, alu_src, alu_op, mem_to_reg, imm_ctrl
//                 : datapath controls
//   err_illegal   : one-cycle pulse in DECODE of an illegal opcode
//   bus_err       : sticky memory-timeout flag
//   halted        : sticky halt indication
// ---------------------------------------------------------------------------
module multicycle_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     run,
    multicycle_ctrl_if.master        mem,
    input  logic                     zero,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic                     pc_src,
    output logic                     reg_we,
    output logic                     alu_src,
    output logic [3:0]               alu_op,
    output logic                     mem_to_reg,
    output logic [1:0]               imm_ctrl,
    output logic                     err_illegal,
    output logic                     bus_err,
    output logic                     halted
);
    import ctrl_pkg::*;

    // state  | meaning
    // FETCH  | idle until run, then imem request held until ready
    // DECODE | decoded header on outputs; illegal -> FETCH, HALT -> HALT
    // EXEC   | branch resolution; ALU -> WB, memory -> MEM
    // MEM    | dmem request held until ready
    // WB     | register-file write
    // HALT   | parked until rst

    state_t state;
    dec_t   dec_q;
    dec_t   dec_in;
    logic   imem_req_q;
    logic   dmem_req_q;
    logic   dmem_we_q;
    logic   fetch_done;
    logic   branch_taken;
    logic   wd_start;
    logic   wd_active;
    logic   wd_ready;
    logic   wd_expire;

    assign mem.imem_req = imem_req_q;
    assign mem.dmem_req = dmem_req_q;
    assign mem.dmem_we  = dmem_we_q;

    assign imm_ctrl = dec_q.imm_ctrl;
    assign alu_op   = dec_q.alu_op;
    assign alu_src  = dec_q.alu_src;

    assign dec_in = decode(mem.instr[31:26]);

    // IR/PC loads must land in the cycle where ready (or zero) is seen, so
    // these strobes are combined from registered state and the live input.
    assign fetch_done = (state == FETCH) && imem_req_q && mem.imem_ready;

    always_comb begin
        branch_taken = 1'b0;
        if ((state == EXEC) && (dec_q.cls == CLS_CTRL)) begin
            case (dec_q.op)
                OP_B:    branch_taken = 1'b1;
                OP_BEQ:  branch_taken = zero;
                OP_BNE:  branch_taken = !zero;
                default: branch_taken = 1'b0;
            endcase
        end
    end

    assign ir_we  = fetch_done;
    assign pc_we  = fetch_done || branch_taken;
    assign pc_src = branch_taken;

    assign wd_start  = ((state == FETCH) && !imem_req_q && run) ||
                       ((state == EXEC) && (dec_q.cls == CLS_MEM));
    assign wd_active = imem_req_q || dmem_req_q;
    assign wd_ready  = imem_req_q ? mem.imem_ready : mem.dmem_ready;

    mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .start  (wd_start),
        .active (wd_active),
        .ready  (wd_ready),
        .expire (wd_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            dec_q       <= '0;
            imem_req_q  <= 1'b0;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            reg_we      <= 1'b0;
            mem_to_reg  <= 1'b0;
            err_illegal <= 1'b0;
            bus_err     <= 1'b0;
            halted      <= 1'b0;
        end else begin
            err_illegal <= 1'b0;
            reg_we      <= 1'b0;
            mem_to_reg  <= 1'b0;
            case (state)
                FETCH: begin
                    if (!imem_req_q) begin
                        if (run) imem_req_q <= 1'b1;
                    end else if (mem.imem_ready) begin
                        imem_req_q  <= 1'b0;
                        dec_q       <= dec_in;
                        err_illegal <= dec_in.illegal;
                        state       <= DECODE;
                    end else if (wd_expire) begin
                        imem_req_q <= 1'b0;
                        bus_err    <= 1'b1;
                        halted     <= 1'b1;
                        state      <= HALT;
                    end
                end
                DECODE: begin
                    if (dec_q.illegal) begin
                        state <= FETCH;
                    end else if ((dec_q.cls == CLS_CTRL) && (dec_q.op == OP_HALT)) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    case (dec_q.cls)
                        CLS_ALU_R, CLS_ALU_I: begin
                            reg_we <= 1'b1;
                            state  <= WB;
                        end
                        CLS_MEM: begin
                            dmem_req_q <= 1'b1;
                            dmem_we_q  <= (dec_q.op == OP_STR);
                            state      <= MEM;
                        end
                        default: state <= FETCH;
                    endcase
                end
                MEM: begin
                    if (mem.dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dec_q.op == OP_STR) begin
                            state <= FETCH;
                        end else begin
                            reg_we     <= 1'b1;
                            mem_to_reg <= 1'b1;
                            state      <= WB;
                        end
                    end else if (wd_expire) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        bus_err    <= 1'b1;
                        halted     <= 1'b1;
                        state      <= HALT;
                    end
                end
                WB:      state <= FETCH;
                HALT:    state <= HALT;
                default: state <= FETCH;
            endcase
        end
    end

endmodule
